// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the ID stage: tracks in-flight destinations, selects
// forwarding distances for rs/rt, raises load-use stalls and counts stall cycles.
module hazard_scoreboard #(
   parameter  int DEPTH    = 3,
   parameter  int LOAD_USE = 1,
   parameter  int CNT_W    = 16,
   localparam int FW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [31:0]      id_instr,
   input  logic             flush,
   output logic             stall,
   output logic             conf_a,
   output logic             conf_b,
   output logic [FW-1:0]    fwd_a,
   output logic [FW-1:0]    fwd_b,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [5:0]    OP_RR   = 6'b000000;
   localparam logic [5:0]    OP_LW   = 6'b100011;
   localparam logic [5:0]    OP_SW   = 6'b101011;
   localparam logic [5:0]    OP_BEQ  = 6'b000100;
   localparam logic [FW-1:0] LU_DIST = FW'(LOAD_USE);

   logic             r_valid [DEPTH];
   logic [4:0]       r_dest  [DEPTH];
   logic             r_load  [DEPTH];
   logic [CNT_W-1:0] r_stall_count;

   logic [5:0]    w_op;
   logic [4:0]    w_rs;
   logic [4:0]    w_rt;
   logic [4:0]    w_rd;
   logic          w_use_rs;
   logic          w_use_rt;
   logic          w_has_dest;
   logic          w_is_load;
   logic [4:0]    w_dest;
   logic          w_dest_valid;
   logic          w_gate;
   logic [FW-1:0] w_fwd_a;
   logic [FW-1:0] w_fwd_b;
   logic          w_load_a;
   logic          w_load_b;
   logic          w_stall;
   logic          w_unused;

   assign w_op     = id_instr[31:26];
   assign w_rs     = id_instr[25:21];
   assign w_rt     = id_instr[20:16];
   assign w_rd     = id_instr[15:11];
   assign w_unused = ^id_instr[10:0];

   // NOTE: every signal driven in always_comb gets a default first, so no path leaves a latch.
   always_comb begin
      w_use_rs   = 1'b0;
      w_use_rt   = 1'b0;
      w_has_dest = 1'b0;
      w_is_load  = 1'b0;
      w_dest     = 5'd0;
      unique case (w_op)
         OP_RR: begin
            w_use_rs   = 1'b1;
            w_use_rt   = 1'b1;
            w_has_dest = 1'b1;
            w_dest     = w_rd;
         end
         OP_LW: begin
            w_use_rs   = 1'b1;
            w_has_dest = 1'b1;
            w_is_load  = 1'b1;
            w_dest     = w_rt;
         end
         OP_SW, OP_BEQ: begin
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_dest_valid = w_has_dest && (w_dest != 5'd0);
   assign w_gate       = id_valid && !flush;

   // Scan oldest to youngest so the youngest matching producer overwrites older ones.
   always_comb begin
      w_fwd_a  = '0;
      w_fwd_b  = '0;
      w_load_a = 1'b0;
      w_load_b = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (r_valid[k] && w_use_rs && (w_rs != 5'd0) && (r_dest[k] == w_rs)) begin
            w_fwd_a  = FW'(k + 1);
            w_load_a = r_load[k];
         end
         if (r_valid[k] && w_use_rt && (w_rt != 5'd0) && (r_dest[k] == w_rt)) begin
            w_fwd_b  = FW'(k + 1);
            w_load_b = r_load[k];
         end
      end
   end

   assign w_stall = w_gate &&
                    ((w_load_a && (w_fwd_a != '0) && (w_fwd_a <= LU_DIST)) ||
                     (w_load_b && (w_fwd_b != '0) && (w_fwd_b <= LU_DIST)));

   assign stall       = w_stall;
   assign fwd_a       = w_gate ? w_fwd_a : '0;
   assign fwd_b       = w_gate ? w_fwd_b : '0;
   assign conf_a      = w_gate && (w_fwd_a != '0);
   assign conf_b      = w_gate && (w_fwd_b != '0);
   assign stall_count = r_stall_count;

   // NOTE: only the valid bits need reset; dest/is_load are never observed while invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) r_valid[k] <= 1'b0;
         r_stall_count <= '0;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            r_valid[k] <= r_valid[k-1];
            r_dest[k]  <= r_dest[k-1];
            r_load[k]  <= r_load[k-1];
         end
         r_valid[0] <= w_gate && !w_stall && w_dest_valid;
         r_dest[0]  <= w_dest;
         r_load[0]  <= w_is_load;
         if (w_stall && (r_stall_count != {CNT_W{1'b1}})) r_stall_count <= r_stall_count + 1'b1;
      end
   end

endmodule
